// File: rtl/fp_wb_collector.sv
// Per-unit result FIFOs plus round-robin writeback arbiter for the FP units.
// Ports: unit-side valid/result/rd/strobes in, in_ready/unit_en out; single wb_* port out.
module fp_wb_collector #(
  parameter int N_UNITS    = 4,
  parameter int DEPTH      = 2,
  parameter int addr_width = 5,
  parameter int XLEN       = 32,
  localparam int SW        = $clog2(N_UNITS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [N_UNITS-1:0]           in_valid,
  input  logic [N_UNITS*XLEN-1:0]      in_result,
  input  logic [N_UNITS*addr_width-1:0] in_rd,
  input  logic [N_UNITS-1:0]           in_reg_write,
  input  logic [N_UNITS-1:0]           in_fp_reg_write,
  output logic [N_UNITS-1:0]           in_ready,
  output logic [N_UNITS-1:0]           unit_en,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [XLEN-1:0]              wb_result,
  output logic [addr_width-1:0]        wb_rd,
  output logic                         wb_reg_write,
  output logic                         wb_fp_reg_write,
  output logic [SW-1:0]                wb_src
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = XLEN + addr_width + 2;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic [EW-1:0] r_mem [N_UNITS][DEPTH];
  logic [PW-1:0] r_wp  [N_UNITS];
  logic [PW-1:0] r_rp  [N_UNITS];
  logic [CW-1:0] r_cnt [N_UNITS];
  logic [SW-1:0] r_rr;
  logic [SW-1:0] r_lock;
  state_t        r_state;

  state_t        w_state_nxt;
  logic          w_lock_ld;
  logic [N_UNITS-1:0] w_ne;
  logic [N_UNITS-1:0] w_push;
  logic [N_UNITS-1:0] w_pop;
  logic [SW-1:0] w_scan;
  logic [SW-1:0] w_grant;
  logic [SW-1:0] w_rr_nxt;
  logic          w_pop_any;
  logic [EW-1:0] w_head;

  always_comb begin
    for (int i = 0; i < N_UNITS; i++) begin
      w_ne[i]     = (r_cnt[i] != '0);
      in_ready[i] = (r_cnt[i] != CW'(DEPTH));
      w_push[i]   = in_valid[i] && in_ready[i] && !flush;
    end
  end

  assign unit_en   = in_ready;
  assign wb_valid  = |w_ne;
  assign w_pop_any = wb_valid && wb_ready;

  // First non-empty FIFO from rr_ptr; descending loop so the
  // closest candidate is the last one written.
  always_comb begin
    w_scan = '0;
    for (int k = N_UNITS - 1; k >= 0; k--) begin
      int j;
      j = int'(r_rr) + k;
      if (j >= N_UNITS) j = j - N_UNITS;
      if (w_ne[j]) w_scan = SW'(j);
    end
  end

  assign w_grant = (r_state == S_HOLD) ? r_lock : w_scan;

  always_comb begin
    int g;
    g = int'(w_grant) + 1;
    if (g >= N_UNITS) g = 0;
    w_rr_nxt = SW'(g);
  end

  always_comb begin
    for (int i = 0; i < N_UNITS; i++)
      w_pop[i] = w_pop_any && (w_grant == SW'(i)) && !flush;
  end

  assign w_head = r_mem[w_grant][r_rp[w_grant]];

  always_comb begin
    wb_result       = '0;
    wb_rd           = '0;
    wb_reg_write    = 1'b0;
    wb_fp_reg_write = 1'b0;
    wb_src          = '0;
    if (wb_valid) begin
      wb_result       = w_head[EW-1 -: XLEN];
      wb_rd           = w_head[2 +: addr_width];
      wb_reg_write    = w_head[1];
      wb_fp_reg_write = w_head[0];
      wb_src          = w_grant;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_UNITS; i++) begin
      if (w_push[i])
        r_mem[i][r_wp[i]] <= {in_result[i*XLEN +: XLEN],
                              in_rd[i*addr_width +: addr_width],
                              in_reg_write[i], in_fp_reg_write[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_UNITS; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < N_UNITS; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_UNITS; i++) begin
        if (w_push[i]) r_wp[i] <= r_wp[i] + PW'(1);
        if (w_pop[i])  r_rp[i] <= r_rp[i] + PW'(1);
        if (w_push[i] && !w_pop[i])
          r_cnt[i] <= r_cnt[i] + CW'(1);
        else if (!w_push[i] && w_pop[i])
          r_cnt[i] <= r_cnt[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rr <= '0;
    else if (w_pop_any && !flush)
      r_rr <= w_rr_nxt;
  end

  // Grant lock FSM: keeps wb_* stable while the WB stage stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lock  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lock_ld) r_lock <= w_grant;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (!flush && wb_valid && !wb_ready) w_state_nxt = S_HOLD;
      S_HOLD:
        if (flush || w_pop_any) w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_lock_ld = (r_state == S_IDLE) && (w_state_nxt == S_HOLD);
  end

endmodule

// File: tb/tb_fp_wb_collector.sv
// Directed self-checking bench for fp_wb_collector.
// Default parameters: 4 units, depth 2, 5-bit rd, 32-bit data.
module tb_fp_wb_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [127:0] in_result = '0;
  logic [19:0] in_rd = '0;
  logic [3:0]  in_reg_write = '0;
  logic [3:0]  in_fp_reg_write = '0;
  logic [3:0]  in_ready;
  logic [3:0]  unit_en;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_fp_reg_write;
  logic [1:0]  wb_src;

  int total = 0;
  int bad = 0;

  fp_wb_collector dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_result(in_result), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_fp_reg_write(in_fp_reg_write),
    .in_ready(in_ready), .unit_en(unit_en),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_result(wb_result), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_fp_reg_write(wb_fp_reg_write),
    .wb_src(wb_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int u, input logic [31:0] res,
                     input logic [4:0] rd, input logic rw, input logic fw);
    in_valid[u]          = 1'b1;
    in_result[u*32 +: 32] = res;
    in_rd[u*5 +: 5]      = rd;
    in_reg_write[u]      = rw;
    in_fp_reg_write[u]   = fw;
  endtask

  task automatic clr();
    in_valid        = '0;
    in_result       = '0;
    in_rd           = '0;
    in_reg_write    = '0;
    in_fp_reg_write = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(wb_valid), 0);
    chk("rst_ready", 32'(in_ready), 32'hF);
    chk("rst_en", 32'(unit_en), 32'hF);
    chk("rst_result", wb_result, 0);
    chk("rst_src", 32'(wb_src), 0);
    tick();
    rst = 1'b0;

    // single result from unit 2
    wb_ready = 1'b1;
    drv(2, 32'h3F800000, 5'd5, 1'b0, 1'b1);
    tick();
    clr();
    chk("single_valid", 32'(wb_valid), 1);
    chk("single_src", 32'(wb_src), 2);
    chk("single_rd", 32'(wb_rd), 5);
    chk("single_res", wb_result, 32'h3F800000);
    chk("single_fw", 32'(wb_fp_reg_write), 1);
    chk("single_rw", 32'(wb_reg_write), 0);
    tick();
    chk("single_done", 32'(wb_valid), 0);
    chk("single_zero", wb_result, 0);

    // unit 3 alone brings rr_ptr back to 0
    drv(3, 32'h1, 5'd1, 1'b0, 1'b1);
    tick();
    clr();
    chk("rr_prep_src", 32'(wb_src), 3);
    tick();
    chk("rr_prep_done", 32'(wb_valid), 0);

    // round robin over all four units
    for (int u = 0; u < 4; u++)
      drv(u, 32'h100 + 32'(u), 5'(u + 10), 1'b0, 1'b1);
    tick();
    clr();
    for (int u = 0; u < 4; u++) begin
      chk("rr_src", 32'(wb_src), 32'(u));
      chk("rr_res", wb_result, 32'h100 + 32'(u));
      tick();
    end
    chk("rr_done", 32'(wb_valid), 0);

    // backpressure on unit 1
    wb_ready = 1'b0;
    drv(1, 32'hA0, 5'd3, 1'b0, 1'b1);
    tick();
    chk("bp_ready1", 32'(in_ready[1]), 1);
    chk("bp_res1", wb_result, 32'hA0);
    drv(1, 32'hB0, 5'd4, 1'b0, 1'b1);
    tick();
    chk("bp_full_ready", 32'(in_ready[1]), 0);
    chk("bp_full_en", 32'(unit_en[1]), 0);
    chk("bp_res2", wb_result, 32'hA0);
    drv(1, 32'hC0, 5'd6, 1'b0, 1'b1);
    tick();
    chk("bp_still_full", 32'(in_ready[1]), 0);
    chk("bp_res3", wb_result, 32'hA0);
    clr();
    wb_ready = 1'b1;
    tick();
    chk("bp_pop_ready", 32'(in_ready[1]), 1);
    chk("bp_second", wb_result, 32'hB0);
    tick();
    chk("bp_done", 32'(wb_valid), 0);

    // unit 3 alone again, rr_ptr -> 0
    drv(3, 32'h2, 5'd2, 1'b0, 1'b1);
    tick();
    clr();
    tick();
    chk("lk_prep_done", 32'(wb_valid), 0);

    // grant lock
    wb_ready = 1'b0;
    drv(3, 32'h33, 5'd13, 1'b0, 1'b1);
    tick();
    clr();
    chk("lk_src_a", 32'(wb_src), 3);
    drv(0, 32'h44, 5'd14, 1'b0, 1'b1);
    tick();
    clr();
    chk("lk_src_b", 32'(wb_src), 3);
    chk("lk_res_b", wb_result, 32'h33);
    tick();
    chk("lk_src_c", 32'(wb_src), 3);
    wb_ready = 1'b1;
    tick();
    chk("lk_next_src", 32'(wb_src), 0);
    chk("lk_next_res", wb_result, 32'h44);
    tick();
    chk("lk_done", 32'(wb_valid), 0);

    // flush
    wb_ready = 1'b0;
    drv(0, 32'h50, 5'd20, 1'b0, 1'b1);
    drv(2, 32'h52, 5'd22, 1'b0, 1'b1);
    tick();
    clr();
    drv(0, 32'h51, 5'd21, 1'b0, 1'b1);
    chk("fl_valid", 32'(wb_valid), 1);
    chk("fl_src", 32'(wb_src), 2);
    tick();
    clr();
    chk("fl_full0", 32'(in_ready[0]), 0);
    flush = 1'b1;
    drv(1, 32'h53, 5'd23, 1'b0, 1'b1);
    tick();
    clr();
    flush = 1'b0;
    chk("fl_after_valid", 32'(wb_valid), 0);
    chk("fl_after_ready", 32'(in_ready), 32'hF);
    wb_ready = 1'b1;
    tick();
    chk("fl_nowb1", 32'(wb_valid), 0);
    tick();
    chk("fl_nowb2", 32'(wb_valid), 0);

    // asynchronous reset mid-stream
    wb_ready = 1'b0;
    drv(0, 32'h60, 5'd24, 1'b0, 1'b1);
    drv(1, 32'h61, 5'd25, 1'b0, 1'b1);
    tick();
    clr();
    chk("ar_pre_valid", 32'(wb_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(wb_valid), 0);
    chk("ar_ready", 32'(in_ready), 32'hF);
    chk("ar_result", wb_result, 0);
    chk("ar_src", 32'(wb_src), 0);
    #1 rst = 1'b0;
    tick();
    chk("ar_after", 32'(wb_valid), 0);

    // entries without strobes are still written back in order
    wb_ready = 1'b1;
    drv(1, 32'h70, 5'd7, 1'b0, 1'b0);
    drv(2, 32'h71, 5'd8, 1'b1, 1'b0);
    tick();
    clr();
    chk("ns_valid", 32'(wb_valid), 1);
    chk("ns_src", 32'(wb_src), 1);
    chk("ns_rd", 32'(wb_rd), 7);
    chk("ns_rw", 32'(wb_reg_write), 0);
    chk("ns_fw", 32'(wb_fp_reg_write), 0);
    tick();
    chk("iw_src", 32'(wb_src), 2);
    chk("iw_rw", 32'(wb_reg_write), 1);
    chk("iw_fw", 32'(wb_fp_reg_write), 0);
    tick();
    chk("iw_done", 32'(wb_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_wb_collector.md
Name: fp_wb_collector

Overview:
- Receiving end of the FP execution pipelines (FMA/R4, fadd/fsub, fmul, fdiv/fsqrt).
- Accepts one completed result per cycle from each of N_UNITS FP units and buffers it in a small per-unit FIFO.
- Round-robin arbitrates the FIFOs onto the single FP/integer register-file writeback port.
- Returns per-unit backpressure so each unit's pipeline enable can be dropped when its buffer is full.

Parameters:
- N_UNITS, 4, number of FP result sources; range 2..8.
- DEPTH, 2, entries per unit FIFO; power of two, range 2..4.
- addr_width, 5, destination register index width.
- XLEN, 32, result data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  N_UNITS  unit i presents a completed result (the unit's p_out signal).
- in_result  in  N_UNITS*XLEN  result of unit i in slice [i*XLEN +: XLEN].
- in_rd  in  N_UNITS*addr_width  destination register of unit i.
- in_reg_write  in  N_UNITS  write to the integer register file (e.g. FP compare, fcvt.w).
- in_fp_reg_write  in  N_UNITS  write to the FP register file.
- in_ready  out  N_UNITS  unit i FIFO can accept an entry this cycle.
- unit_en  out  N_UNITS  pipeline enable for unit i; equals in_ready[i].
- wb_valid  out  1  writeback entry present.
- wb_ready  in  1  register file / WB stage accepts the entry.
- wb_result  out  XLEN  writeback data.
- wb_rd  out  addr_width  writeback destination.
- wb_reg_write  out  1  integer RF write strobe qualifier.
- wb_fp_reg_write  out  1  FP RF write strobe qualifier.
- wb_src  out  $clog2(N_UNITS)  index of the granted unit.

Behaviour:
- Per-unit FIFO: wr_ptr, rd_ptr, count (0..DEPTH) registers; storage holds {result, rd, reg_write, fp_reg_write}.
- in_ready[i] = (count[i] != DEPTH). Derived from registered count only; no same-cycle pop-through when full.
- Push i: in_valid[i] && in_ready[i]. If in_valid[i] is high while in_ready[i] is low, the entry is not taken. The unit must hold it (unit_en low freezes its pipeline).
- Entries with in_reg_write = in_fp_reg_write = 0 are still buffered and written back. WB ignores them; order is preserved.
- wb_valid = OR of (count[i] != 0). wb_* outputs are combinational from the head of the granted FIFO. Latency from push to wb_valid is 1 cycle minimum.
- Pop: wb_valid && wb_ready pops the granted FIFO. Push and pop on the same FIFO in the same cycle leave count unchanged.
- Arbitration:
  - rr_ptr register.
  - The grant is the first non-empty FIFO scanning rr_ptr, rr_ptr+1, … (mod N_UNITS).
  - On pop, rr_ptr <= grant+1 (mod N_UNITS).
- Grant lock:
  - State IDLE: no lock.
  - State HOLD is entered when wb_valid && !wb_ready. lock_idx <= grant.
  - While in HOLD, grant = lock_idx, so wb_* are stable until accepted.
  - HOLD -> IDLE on pop or flush.
- Ordering: FIFO order within a unit is guaranteed. There is no ordering guarantee across units; the hazard unit prevents WAW between units.
- flush:
  - Next cycle, all count/ptr = 0, FSM = IDLE, rr_ptr unchanged.
  - flush overrides a same-cycle push and pop; the pushed entry is dropped.
  - wb_valid may be high in the flush cycle. The WB stage qualifies it with flush.
- Reset (rst high, asynchronous):
  - count = 0, pointers = 0, rr_ptr = 0, FSM = IDLE.
  - Outputs: wb_valid = 0, wb_result = 0, wb_rd = 0, wb_reg_write = 0, wb_fp_reg_write = 0, wb_src = 0; in_ready = unit_en = all ones.
  - Reset asserted mid-transfer discards all entries without a writeback.
- When wb_valid = 0, wb_result, wb_rd and the strobes are driven 0 (no X propagation).
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty is decided by count, not pointer compare.

Test Plan:
- Single result: unit 2 pushes result=0x3F800000, rd=5, fp_reg_write=1; wb_ready=1 -> next cycle wb_valid=1, wb_src=2, wb_rd=5, wb_result=0x3F800000; the cycle after, wb_valid=0.
- Round-robin: all 4 units push one entry in the same cycle, rr_ptr=0, wb_ready=1 -> wb_src sequence 0,1,2,3 over 4 consecutive cycles; rr_ptr ends at 0.
- Backpressure/full: wb_ready=0, unit 1 pushes 3 consecutive cycles -> entries 1 and 2 accepted; in_ready[1]=0 and unit_en[1]=0 from cycle 3; wb_result is stable at the first entry. wb_ready=1 -> in_ready[1]=1 one cycle after the pop.
- Grant lock: wb_ready=0 with unit 3 granted, then unit 0 pushes -> wb_src stays 3 until wb_ready=1; the next grant is 0.
- Flush: 2 entries in unit 0, 1 in unit 2, push to unit 1 in the flush cycle -> next cycle wb_valid=0, all in_ready=1, no writeback of any flushed entry.
- Async reset: assert rst mid-stream between clock edges -> wb_valid=0 and in_ready=all ones immediately, before the next clk edge.
